// File: rtl/challenge_descrambler.sv
// Challenge descrambler: XORs words with an 8-bit Fibonacci LFSR keystream.
// Define CHALLENGE_DESCRAMBLER_RESYNC_EN to reload the seed every RESYNC_PERIOD words.
module challenge_descrambler #(
    parameter int RESYNC_PERIOD = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] seed_in,
    input  logic       seed_load,
    input  logic [7:0] scr_in,
    input  logic       scr_valid,
    output logic       scr_ready,
    output logic [7:0] chall_out,
    output logic       chall_valid,
    input  logic       chall_ready,
    output logic [7:0] word_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_nxt;
    logic [7:0] lfsr;
    logic [7:0] lfsr_step;
    logic [7:0] seed_eff;
    logic       accept;

    if (RESYNC_PERIOD < 1 || RESYNC_PERIOD > 255) begin : g_bad_period
        $error("RESYNC_PERIOD out of range 1..255");
    end

    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    // An all-zero seed would lock the LFSR at zero forever.
    assign seed_eff  = (seed_in == 8'h00) ? 8'h01 : seed_in;
    assign accept    = scr_valid & scr_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scr_ready = 1'b0;
        if (seed_load) begin
            state_nxt = RUN;
        end
        if (state == RUN && !seed_load && (!chall_valid || chall_ready)) begin
            scr_ready = 1'b1;
        end
    end

`ifdef CHALLENGE_DESCRAMBLER_RESYNC_EN
    logic [7:0] seed_copy;
    logic [7:0] rs_cnt;
    logic       rs_hit;

    assign rs_hit = (rs_cnt == 8'(RESYNC_PERIOD - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seed_copy <= 8'h01;
            rs_cnt    <= 8'h00;
        end else if (seed_load) begin
            seed_copy <= seed_eff;
            rs_cnt    <= 8'h00;
        end else if (accept) begin
            rs_cnt <= rs_hit ? 8'h00 : rs_cnt + 8'h01;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr        <= 8'h01;
            chall_out   <= 8'h00;
            chall_valid <= 1'b0;
            word_cnt    <= 8'h00;
        end else if (seed_load) begin
            lfsr        <= seed_eff;
            chall_valid <= 1'b0;
            word_cnt    <= 8'h00;
        end else if (accept) begin
            chall_out   <= scr_in ^ lfsr;
            chall_valid <= 1'b1;
            word_cnt    <= word_cnt + 8'h01;
`ifdef CHALLENGE_DESCRAMBLER_RESYNC_EN
            lfsr        <= rs_hit ? seed_copy : lfsr_step;
`else
            lfsr        <= lfsr_step;
`endif
        end else if (chall_ready) begin
            chall_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_challenge_descrambler.sv
// Scoreboard bench for challenge_descrambler; keystream model runs in the bench.
module tb_challenge_descrambler;

`ifdef CHALLENGE_DESCRAMBLER_RESYNC_EN
    localparam int RP = 2;
`else
    localparam int RP = 16;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic       seed_load = 1'b0;
    logic [7:0] scr_in = 8'h00;
    logic       scr_valid = 1'b0;
    logic       scr_ready;
    logic [7:0] chall_out;
    logic       chall_valid;
    logic       chall_ready = 1'b0;
    logic [7:0] word_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] m_seed, m_lfsr, m_cnt, m_rs;
    logic       m_valid;

    challenge_descrambler #(.RESYNC_PERIOD(RP)) dut (
        .clock(clock), .reset_n(reset_n), .seed_in(seed_in),
        .seed_load(seed_load), .scr_in(scr_in), .scr_valid(scr_valid),
        .scr_ready(scr_ready), .chall_out(chall_out),
        .chall_valid(chall_valid), .chall_ready(chall_ready),
        .word_cnt(word_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_seed(input logic [7:0] s);
        m_seed  = (s == 8'h00) ? 8'h01 : s;
        m_lfsr  = m_seed;
        m_rs    = 8'h00;
        m_cnt   = 8'h00;
        m_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [7:0] w);
        exp_q.push_back(w ^ m_lfsr);
        m_cnt = m_cnt + 8'h01;
        m_rs  = m_rs + 8'h01;
`ifdef CHALLENGE_DESCRAMBLER_RESYNC_EN
        if (m_rs == 8'(RP)) begin
            m_lfsr = m_seed;
            m_rs   = 8'h00;
        end else begin
            m_lfsr = step(m_lfsr);
        end
`else
        m_lfsr = step(m_lfsr);
`endif
    endtask

    task automatic load_seed(input logic [7:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        model_seed(s);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({scr_ready, chall_valid, chall_out, word_cnt} !== 18'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0",
                     {scr_ready, chall_valid, chall_out, word_cnt});
        end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        scr_valid = 1'b1;
        scr_in    = 8'h33;
        chall_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (scr_ready !== 1'b0 || chall_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_ready got=%b%b exp=00",
                         scr_ready, chall_valid);
            end
            tick();
        end
        scr_valid = 1'b0;
    endtask

    task automatic test_seed_a5();
        logic [7:0] lit [3];
        logic [7:0] e;
        lit = '{8'hA5, 8'h4A, 8'h95};
        load_seed(8'hA5);
        chall_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            scr_in = 8'h00;
            scr_valid = 1'b1;
            model_accept(8'h00);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (chall_valid !== 1'b1 || chall_out !== e) begin
                failures++;
                $display("FAIL a5_word%0d got=%h/%b exp=%h/1",
                         i, chall_out, chall_valid, e);
            end
`ifndef CHALLENGE_DESCRAMBLER_RESYNC_EN
            checks++;
            if (chall_out !== lit[i]) begin
                failures++;
                $display("FAIL a5_lit%0d got=%h exp=%h",
                         i, chall_out, lit[i]);
            end
`endif
        end
        scr_valid = 1'b0;
        checks++;
        if (word_cnt !== 8'd3) begin
            failures++;
            $display("FAIL a5_cnt got=%0d exp=3", word_cnt);
        end
        tick();
    endtask

    task automatic test_zero_seed();
        load_seed(8'h00);
        chall_ready = 1'b1;
        scr_in = 8'h00;
        scr_valid = 1'b1;
        tick();
        scr_valid = 1'b0;
        checks++;
        if (chall_out !== 8'h01 || chall_valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_seed got=%h exp=01", chall_out);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        load_seed(8'hA5);
        chall_ready = 1'b0;
        scr_in = 8'hFF;
        scr_valid = 1'b1;
        model_accept(8'hFF);
        tick();
        e = exp_q.pop_front();
        scr_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (chall_out !== e || e !== 8'h5A || scr_ready !== 1'b0 ||
                chall_valid !== 1'b1 || word_cnt !== 8'd1) begin
                failures++;
                $display("FAIL bp_hold%0d got=%h r=%b v=%b c=%0d exp=5A",
                         i, chall_out, scr_ready, chall_valid, word_cnt);
            end
            tick();
        end
        chall_ready = 1'b1;
        #1;
        checks++;
        if (scr_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got=%b exp=1", scr_ready);
        end
        model_accept(8'h00);
        tick();
        scr_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (chall_out !== e || chall_out !== 8'h4A) begin
            failures++;
            $display("FAIL bp_next got=%h exp=4A", chall_out);
        end
        tick();
    endtask

    task automatic test_seed_priority();
        logic [7:0] e;
        load_seed(8'hA5);
        chall_ready = 1'b1;
        scr_in = 8'h00;
        scr_valid = 1'b1;
        tick();
        seed_in = 8'h3C;
        seed_load = 1'b1;
        scr_in = 8'h11;
        #1;
        checks++;
        if (scr_ready !== 1'b0) begin
            failures++;
            $display("FAIL prio_ready got=%b exp=0", scr_ready);
        end
        tick();
        seed_load = 1'b0;
        model_seed(8'h3C);
        checks++;
        if (chall_valid !== 1'b0 || word_cnt !== 8'h00) begin
            failures++;
            $display("FAIL prio_clear got=%b/%0d exp=0/0",
                     chall_valid, word_cnt);
        end
        model_accept(8'h11);
        tick();
        scr_valid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (chall_out !== e || e !== 8'h2D || chall_valid !== 1'b1) begin
            failures++;
            $display("FAIL prio_new got=%h exp=2D", chall_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_ready, acc;
        logic [7:0] e;
        load_seed(8'($urandom_range(1, 255)));
        for (int i = 0; i < 300; i++) begin
            scr_valid   = ($urandom_range(0, 3) != 0);
            chall_ready = ($urandom_range(0, 3) != 0);
            scr_in      = 8'($urandom);
            #1;
            exp_ready = !m_valid || chall_ready;
            checks++;
            if (scr_ready !== exp_ready) begin
                failures++;
                $display("FAIL b2b_ready%0d got=%b exp=%b",
                         i, scr_ready, exp_ready);
            end
            acc = scr_valid && exp_ready;
            if (acc) begin
                model_accept(scr_in);
                m_valid = 1'b1;
            end else if (chall_ready) begin
                m_valid = 1'b0;
            end
            tick();
            checks++;
            if (chall_valid !== m_valid || word_cnt !== m_cnt) begin
                failures++;
                $display("FAIL b2b_state%0d got=%b/%0d exp=%b/%0d",
                         i, chall_valid, word_cnt, m_valid, m_cnt);
            end
            if (acc) begin
                e = exp_q.pop_front();
                checks++;
                if (chall_out !== e) begin
                    failures++;
                    $display("FAIL b2b_data%0d got=%h exp=%h",
                             i, chall_out, e);
                end
            end
        end
        scr_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        load_seed(8'h77);
        chall_ready = 1'b0;
        scr_in = 8'h55;
        scr_valid = 1'b1;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (chall_valid !== 1'b0 || scr_ready !== 1'b0 ||
            word_cnt !== 8'h00 || chall_out !== 8'h00) begin
            failures++;
            $display("FAIL rst_mid got=%b%b/%0d/%h exp=00/0/00",
                     chall_valid, scr_ready, word_cnt, chall_out);
        end
        tick();
        reset_n = 1'b1;
        chall_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (scr_ready !== 1'b0 || chall_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_idle%0d got=%b%b exp=00",
                         i, scr_ready, chall_valid);
            end
        end
        scr_valid = 1'b0;
    endtask

`ifdef CHALLENGE_DESCRAMBLER_RESYNC_EN
    task automatic test_resync();
        logic [7:0] lit [4];
        logic [7:0] e;
        lit = '{8'hA5, 8'h4A, 8'hA5, 8'h4A};
        load_seed(8'hA5);
        chall_ready = 1'b1;
        scr_in = 8'h00;
        scr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            model_accept(8'h00);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (chall_out !== e || chall_out !== lit[i]) begin
                failures++;
                $display("FAIL resync%0d got=%h exp=%h",
                         i, chall_out, lit[i]);
            end
        end
        scr_valid = 1'b0;
        checks++;
        if (word_cnt !== 8'd4) begin
            failures++;
            $display("FAIL resync_cnt got=%0d exp=4", word_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_seed_a5();
        test_zero_seed();
        test_backpressure();
        test_seed_priority();
        test_back_to_back();
        test_reset_midstream();
`ifdef CHALLENGE_DESCRAMBLER_RESYNC_EN
        test_resync();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
